// File: rtl/demorgan_hw_checker.sv
// rtl/demorgan_hw_checker.sv - on-board stimulus generator and response checker for a De Morgan gate pair
//
// Purpose:
//   Sweeps {A,B} through 00,01,10,11 (NUM_PASSES times), holds each vector
//   for SETTLE_CYCLES+1 cycles, samples the six gate outputs on the last cycle
//   and compares them with the golden De Morgan function. Mismatches are
//   counted (saturating) and the first failing vector/mask is captured.
//
// Ports:
//   i_clk               system clock, rising edge
//   i_reset             synchronous active-high reset
//   i_start             begin a run (honoured only in IDLE)
//   i_dut_resp[5:0]     {nA,nB,nAandnB,nAorB,nAornB,nAandB}, bit0 = nAandB
//   o_a, o_b            registered stimulus
//   o_busy              high while settling/sampling
//   o_done              one-cycle pulse at run end
//   o_pass              run finished with zero mismatches
//   o_err_count         saturating mismatch count
//   o_fail_valid        at least one mismatch this run
//   o_first_fail_vec    {A,B} of the first mismatch
//   o_first_fail_mask   XOR mask of the first mismatch

module demorgan_hw_checker #(
    parameter int SETTLE_CYCLES = 1,
    parameter int NUM_PASSES    = 1,
    parameter int ERR_W         = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [5:0]       i_dut_resp,
    output logic             o_a,
    output logic             o_b,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [ERR_W-1:0] o_err_count,
    output logic             o_fail_valid,
    output logic [1:0]       o_first_fail_vec,
    output logic [5:0]       o_first_fail_mask
);

    localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t             r_state;
    logic               r_a;
    logic               r_b;
    logic [1:0]         r_vec;
    logic [PASS_W-1:0]  r_pass_cnt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic [ERR_W-1:0]   r_err;
    logic               r_fail_valid;
    logic [1:0]         r_ff_vec;
    logic [5:0]         r_ff_mask;

    logic [5:0]         w_expected;
    logic [5:0]         w_mask;
    logic               w_mismatch;
    logic [ERR_W-1:0]   w_err_next;
    logic               w_last_vec;
    logic               w_last_pass;
    logic               w_settled;

    // Golden response for the vector currently driven on A/B
    assign w_expected = {~r_a, ~r_b, ~r_a & ~r_b, ~(r_a | r_b), ~r_a | ~r_b, ~(r_a & r_b)};
    assign w_mask     = i_dut_resp ^ w_expected;
    assign w_mismatch = |w_mask;
    // Count including the current sample so pass reflects the final vector too
    assign w_err_next = (w_mismatch && !(&r_err)) ? r_err + ERR_W'(1) : r_err;
    assign w_last_vec  = (r_vec == 2'd3);
    assign w_last_pass = (r_pass_cnt == PASS_W'(NUM_PASSES - 1));
    assign w_settled   = (r_cnt == CNT_W'(SETTLE_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_a          <= 1'b0;
            r_b          <= 1'b0;
            r_vec        <= 2'd0;
            r_pass_cnt   <= '0;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err        <= '0;
            r_fail_valid <= 1'b0;
            r_ff_vec     <= 2'd0;
            r_ff_mask    <= 6'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_a          <= 1'b0;
                        r_b          <= 1'b0;
                        r_vec        <= 2'd0;
                        r_pass_cnt   <= '0;
                        r_cnt        <= '0;
                        r_err        <= '0;
                        r_fail_valid <= 1'b0;
                        r_ff_vec     <= 2'd0;
                        r_ff_mask    <= 6'd0;
                        r_pass       <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (w_settled) begin
                        r_cnt   <= '0;
                        r_state <= S_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_SAMPLE: begin
                    r_err <= w_err_next;
                    if (w_mismatch && !r_fail_valid) begin
                        r_fail_valid <= 1'b1;
                        r_ff_vec     <= {r_a, r_b};
                        r_ff_mask    <= w_mask;
                    end
                    if (!w_last_vec) begin
                        r_vec        <= r_vec + 2'd1;
                        {r_a, r_b}   <= r_vec + 2'd1;
                        r_state      <= S_SETTLE;
                    end else if (!w_last_pass) begin
                        r_vec        <= 2'd0;
                        {r_a, r_b}   <= 2'd0;
                        r_pass_cnt   <= r_pass_cnt + PASS_W'(1);
                        r_state      <= S_SETTLE;
                    end else begin
                        // A/B stay at 11 until the next accepted start
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == '0);
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_a               = r_a;
    assign o_b               = r_b;
    assign o_busy            = r_busy;
    assign o_done            = r_done;
    assign o_pass            = r_pass;
    assign o_err_count       = r_err;
    assign o_fail_valid      = r_fail_valid;
    assign o_first_fail_vec  = r_ff_vec;
    assign o_first_fail_mask = r_ff_mask;

endmodule

// File: tb/tb_demorgan_hw_checker.sv
// tb/tb_demorgan_hw_checker.sv - self-checking bench for demorgan_hw_checker

module tb_demorgan_hw_checker;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Instance parameters: SETTLE_CYCLES / NUM_PASSES / ERR_W
    int sc[3] = '{1, 1, 2};
    int np[3] = '{1, 2, 2};
    int ew[3] = '{8, 8, 2};

    logic       start_v[3];
    logic [5:0] s0_v[3];
    logic [5:0] s1_v[3];
    logic [5:0] inv_v[3];
    logic [5:0] resp[3];
    logic       a_o[3];
    logic       b_o[3];
    logic       busy_o[3];
    logic       done_o[3];
    logic       pass_o[3];
    logic       fv_o[3];
    logic [1:0] fvec_o[3];
    logic [5:0] fmask_o[3];
    logic [7:0] ec0;
    logic [7:0] ec1;
    logic [1:0] ec2;

    int n_cmp = 0;
    int n_err = 0;

    // Gate pair as it should behave on the board
    function automatic logic [5:0] golden(input logic a, input logic b);
        return {~a, ~b, ~a & ~b, ~(a | b), ~a | ~b, ~(a & b)};
    endfunction

    // Faulty gate model: stuck-at-0, stuck-at-1, then inversion
    for (genvar g = 0; g < 3; g++) begin : g_gates
        assign resp[g] = ((golden(a_o[g], b_o[g]) & ~s0_v[g]) | s1_v[g]) ^ inv_v[g];
    end

    demorgan_hw_checker #(.SETTLE_CYCLES(1), .NUM_PASSES(1), .ERR_W(8)) u0 (
        .i_clk(clk), .i_reset(reset), .i_start(start_v[0]), .i_dut_resp(resp[0]),
        .o_a(a_o[0]), .o_b(b_o[0]), .o_busy(busy_o[0]), .o_done(done_o[0]),
        .o_pass(pass_o[0]), .o_err_count(ec0), .o_fail_valid(fv_o[0]),
        .o_first_fail_vec(fvec_o[0]), .o_first_fail_mask(fmask_o[0]));

    demorgan_hw_checker #(.SETTLE_CYCLES(1), .NUM_PASSES(2), .ERR_W(8)) u1 (
        .i_clk(clk), .i_reset(reset), .i_start(start_v[1]), .i_dut_resp(resp[1]),
        .o_a(a_o[1]), .o_b(b_o[1]), .o_busy(busy_o[1]), .o_done(done_o[1]),
        .o_pass(pass_o[1]), .o_err_count(ec1), .o_fail_valid(fv_o[1]),
        .o_first_fail_vec(fvec_o[1]), .o_first_fail_mask(fmask_o[1]));

    demorgan_hw_checker #(.SETTLE_CYCLES(2), .NUM_PASSES(2), .ERR_W(2)) u2 (
        .i_clk(clk), .i_reset(reset), .i_start(start_v[2]), .i_dut_resp(resp[2]),
        .o_a(a_o[2]), .o_b(b_o[2]), .o_busy(busy_o[2]), .o_done(done_o[2]),
        .o_pass(pass_o[2]), .o_err_count(ec2), .o_fail_valid(fv_o[2]),
        .o_first_fail_vec(fvec_o[2]), .o_first_fail_mask(fmask_o[2]));

    function automatic int get_ec(input int k);
        if (k == 0) return int'(ec0);
        if (k == 1) return int'(ec1);
        return int'(ec2);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: walk every sample of the run and tally the outcome
    task automatic model(input int k, input logic [5:0] s0, input logic [5:0] s1,
                         input logic [5:0] inv, output int err, output int fv,
                         output int fvec, output int fmask, output int pass);
        int cnt = 0;
        fv = 0; fvec = 0; fmask = 0;
        for (int p = 0; p < np[k]; p++) begin
            for (int v = 0; v < 4; v++) begin
                logic a, b;
                logic [5:0] g, r, m;
                a = v[1]; b = v[0];
                g = {!a, !b, !a && !b, !(a || b), !a || !b, !(a && b)};
                r = ((g & ~s0) | s1) ^ inv;
                m = r ^ g;
                if (m != 0) begin
                    if (fv == 0) begin fv = 1; fvec = v; fmask = int'(m); end
                    cnt++;
                end
            end
        end
        err  = (cnt > (1 << ew[k]) - 1) ? (1 << ew[k]) - 1 : cnt;
        pass = (cnt == 0) ? 1 : 0;
    endtask

    // Start a run on instance k, follow it to done; n counts edges after the accept edge
    task automatic run(input int k, input bit repulse, input string tag);
        int total, done_at, seq_bad;
        total = 4 * (sc[k] + 1) * np[k];
        done_at = -1; seq_bad = 0;
        @(negedge clk) start_v[k] = 1'b1;
        for (int n = 0; n <= total + 20; n++) begin
            @(negedge clk);
            start_v[k] = repulse && (n == 1 || n == 4);
            if (done_o[k]) begin done_at = n; break; end
            if ({a_o[k], b_o[k]} != 2'((n / (sc[k] + 1)) % 4) || !busy_o[k]) seq_bad++;
        end
        start_v[k] = 1'b0;
        check({tag, " vector_seq"}, seq_bad, 0);
        check({tag, " done_edge"}, done_at, total);
    endtask

    task automatic check_results(input int k, input string tag, input int err, input int fv,
                                 input int fvec, input int fmask, input int pass);
        check({tag, " err_count"}, get_ec(k), err);
        check({tag, " fail_valid"}, int'(fv_o[k]), fv);
        check({tag, " first_vec"}, int'(fvec_o[k]), fvec);
        check({tag, " first_mask"}, int'(fmask_o[k]), fmask);
        check({tag, " pass"}, int'(pass_o[k]), pass);
        check({tag, " busy_at_done"}, int'(busy_o[k]), 0);
        @(negedge clk);
        check({tag, " done_width"}, int'(done_o[k]), 0);
        check({tag, " ab_hold"}, int'({a_o[k], b_o[k]}), 3);
    endtask

    typedef struct {
        int         k;
        logic [5:0] s0, s1, inv;
        int         err, fv, fvec, fmask, pass;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int e, f, fvv, fm, p, done1, done2;
        tbl[0] = '{0, 6'h00, 6'h00, 6'h00, 0, 0, 0, 0,     1};
        tbl[1] = '{0, 6'h00, 6'h01, 6'h00, 1, 1, 3, 6'h01, 0};
        tbl[2] = '{0, 6'h01, 6'h00, 6'h00, 3, 1, 0, 6'h01, 0};
        tbl[3] = '{0, 6'h00, 6'h20, 6'h00, 2, 1, 2, 6'h20, 0};
        tbl[4] = '{0, 6'h00, 6'h00, 6'h02, 4, 1, 0, 6'h02, 0};
        tbl[5] = '{1, 6'h20, 6'h00, 6'h00, 4, 1, 0, 6'h20, 0};
        tbl[6] = '{2, 6'h00, 6'h00, 6'h3f, 3, 1, 0, 6'h3f, 0};

        for (int k = 0; k < 3; k++) begin
            start_v[k] = 1'b0; s0_v[k] = '0; s1_v[k] = '0; inv_v[k] = '0;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++)
            check("reset_outputs", int'({a_o[k], b_o[k], busy_o[k], done_o[k], pass_o[k],
                  fv_o[k], fvec_o[k], fmask_o[k]}) + get_ec(k), 0);

        for (int i = 0; i < 7; i++) begin
            int k;
            k = tbl[i].k;
            s0_v[k] = tbl[i].s0; s1_v[k] = tbl[i].s1; inv_v[k] = tbl[i].inv;
            run(k, 1'b0, $sformatf("tbl%0d", i));
            check_results(k, $sformatf("tbl%0d", i), tbl[i].err, tbl[i].fv,
                          tbl[i].fvec, tbl[i].fmask, tbl[i].pass);
            s0_v[k] = '0; s1_v[k] = '0; inv_v[k] = '0;
        end

        // start re-pulsed mid-run on a faulty gate: results must be untouched
        s1_v[0] = 6'h01;
        run(0, 1'b1, "repulse");
        check_results(0, "repulse", 1, 1, 3, 6'h01, 0);
        s1_v[0] = '0;

        // reset for one cycle at edge 3 of a run
        @(negedge clk) start_v[0] = 1'b1;
        @(negedge clk) start_v[0] = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        check("midrun_reset_outputs", int'({a_o[0], b_o[0], busy_o[0], done_o[0], pass_o[0],
              fv_o[0], fvec_o[0], fmask_o[0]}) + get_ec(0), 0);
        done1 = 0;
        repeat (20) begin
            @(negedge clk);
            if (done_o[0] || busy_o[0]) done1++;
        end
        check("midrun_reset_no_done", done1, 0);
        run(0, 1'b0, "after_reset");
        check_results(0, "after_reset", 0, 0, 0, 0, 1);

        // start held high across DONE: second run begins right after IDLE
        done1 = -1; done2 = -1;
        @(negedge clk) start_v[0] = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done_o[0]) begin
                if (done1 < 0) done1 = n;
                else begin done2 = n; break; end
            end
        end
        start_v[0] = 1'b0;
        check("held_start_first_done", done1, 8);
        check("held_start_second_done", done2, 18);
        repeat (4) @(negedge clk);
        check("held_start_idle", int'(busy_o[0]), 0);

        // randomized faults against the reference model
        for (int i = 0; i < 12; i++) begin
            int k;
            k = $urandom_range(0, 2);
            s0_v[k]  = 6'($urandom & $urandom);
            s1_v[k]  = 6'($urandom & $urandom) & ~s0_v[k];
            inv_v[k] = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h00;
            model(k, s0_v[k], s1_v[k], inv_v[k], e, f, fvv, fm, p);
            run(k, 1'b0, $sformatf("rnd%0d", i));
            check_results(k, $sformatf("rnd%0d", i), e, f, fvv, fm, p);
            s0_v[k] = '0; s1_v[k] = '0; inv_v[k] = '0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
